// File: rtl/csoc_stim_bridge.sv
// ---------------------------------------------------------------------------
// csoc_stim_bridge
//
// Purpose: bridges a UART byte stream to the CSoC test chip. Received bytes
// are packed LSB-first into DATA_W-wide words and queued in a DEPTH-entry
// FIFO. The bridge generates the divided chip clock and the chip reset
// sequence, launches one queued word per chip clock period, and returns
// words captured from the chip to the UART transmitter as bytes, LSB first.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   rx_valid/rx_data  one-cycle strobe with a received byte
//   tx_data/tx_valid  byte offered to the UART transmitter
//   tx_ready          transmitter accepts tx_data
//   scan_en/test_mode requested chip scan-enable / test-mode levels
//   csoc_clk          divided chip clock (period 2*CLK_DIV clk)
//   csoc_rstn         chip reset, active low
//   csoc_test_se/_tm  chip scan enable / test mode, updated on falling edges
//   csoc_uart_write   csoc_data_i carries a valid word
//   csoc_uart_read    chip presents a word on csoc_data_o
//   csoc_data_i       word to the chip
//   csoc_data_o       word from the chip
//   fifo_level        registered stimulus FIFO occupancy, 0..DEPTH
//   overflow          sticky, a word was lost because the FIFO was full
//   rsp_drop          sticky, a response was lost because TX was busy
//
// Handshake: a TX byte is transferred in every clk cycle where tx_valid and
// tx_ready are both high; once tx_valid is raised, tx_valid and tx_data
// hold until that transfer happens.
// ---------------------------------------------------------------------------
module csoc_stim_bridge #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 8,
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_data,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   input  logic                      scan_en,
   input  logic                      test_mode,
   output logic                      csoc_clk,
   output logic                      csoc_rstn,
   output logic                      csoc_test_se,
   output logic                      csoc_test_tm,
   output logic                      csoc_uart_write,
   input  logic                      csoc_uart_read,
   output logic [DATA_W-1:0]         csoc_data_i,
   input  logic [DATA_W-1:0]         csoc_data_o,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      overflow,
   output logic                      rsp_drop
);

   localparam int NB = DATA_W / 8;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [0:0] {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

   // ---------------- divider ----------------
   logic [DW-1:0] div_cnt_q;
   logic          csoc_clk_q;
   logic          toggle_w;
   logic          rise_ev;
   logic          fall_ev;

   assign toggle_w = (div_cnt_q == DW'(CLK_DIV - 1));
   assign rise_ev  = toggle_w & ~csoc_clk_q;
   assign fall_ev  = toggle_w &  csoc_clk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q  <= '0;
         csoc_clk_q <= 1'b0;
      end else if (toggle_w) begin
         div_cnt_q  <= '0;
         csoc_clk_q <= ~csoc_clk_q;
      end else begin
         div_cnt_q  <= div_cnt_q + DW'(1);
      end
   end

   // ---------------- chip reset sequence ----------------
   logic [RW-1:0] rst_cnt_q;
   logic          rstn_q;
   logic          rstn_d;

   // The counter saturates at RST_CYCLES; release happens on the first
   // falling edge after that many rising edges have been seen.
   assign rstn_d = rstn_q | (fall_ev & (rst_cnt_q == RW'(RST_CYCLES)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_cnt_q <= '0;
         rstn_q    <= 1'b0;
      end else begin
         if (rise_ev && (rst_cnt_q != RW'(RST_CYCLES)))
            rst_cnt_q <= rst_cnt_q + RW'(1);
         rstn_q <= rstn_d;
      end
   end

   // ---------------- test pins ----------------
   logic se_q;
   logic tm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         se_q <= 1'b0;
         tm_q <= 1'b0;
      end else if (fall_ev) begin
         se_q <= scan_en;
         tm_q <= test_mode;
      end
   end

   // ---------------- packer ----------------
   logic [KW-1:0]     k_q;
   logic [DATA_W-1:0] pk_q;
   logic [DATA_W-1:0] word_w;
   logic              rx_acc;
   logic              push;

   assign rx_acc = rx_valid & rstn_q;
   assign push   = rx_acc & (k_q == KW'(NB - 1));

   // word_w is the packer contents with the incoming byte merged in, so the
   // completed word can be written to the FIFO in the same cycle.
   always_comb begin
      word_w = pk_q;
      for (int b = 0; b < NB; b++) begin
         if (k_q == KW'(b)) word_w[b*8 +: 8] = rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q  <= '0;
         pk_q <= '0;
      end else if (rx_acc) begin
         pk_q <= word_w;
         k_q  <= push ? '0 : k_q + KW'(1);
      end
   end

   // ---------------- stimulus FIFO ----------------
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic              full_w;
   logic              push_ok;
   logic              launch_en;
   logic              pop;

   assign full_w    = (level_q == LW'(DEPTH));
   assign push_ok   = push & ~full_w;
   assign launch_en = fall_ev & rstn_d;
   // Pop looks at the registered level, so a word pushed into an empty FIFO
   // waits for the next falling edge.
   assign pop       = launch_en & (level_q != '0);

   always_comb begin
      level_d = level_q;
      if (push_ok && !pop)
         level_d = level_q + LW'(1);
      else if (pop && !push_ok)
         level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= word_w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // ---------------- launch ----------------
   // Launching on the falling edge keeps the word stable across the chip's
   // rising edge and holds it for one full chip clock period.
   logic              write_q;
   logic [DATA_W-1:0] data_i_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q  <= 1'b0;
         data_i_q <= '0;
      end else if (launch_en) begin
         write_q <= pop;
         if (pop) data_i_q <= mem_q[rd_ptr_q];
      end
   end

   // ---------------- capture and serializer ----------------
   ser_state_t        ser_q;
   ser_state_t        ser_d;
   logic [KW-1:0]     b_q;
   logic [KW-1:0]     b_d;
   logic [DATA_W-1:0] sh_q;
   logic [DATA_W-1:0] sh_d;
   logic              cap_w;
   logic              drop_w;
   logic [7:0]        tx_byte_w;

   assign cap_w = rise_ev & rstn_q & csoc_uart_read;

   always_comb begin
      ser_d  = ser_q;
      b_d    = b_q;
      sh_d   = sh_q;
      drop_w = 1'b0;
      case (ser_q)
         SER_IDLE: begin
            if (cap_w) begin
               sh_d  = csoc_data_o;
               b_d   = '0;
               ser_d = SER_SEND;
            end
         end
         SER_SEND: begin
            // Busy until the cycle after the last byte is accepted.
            if (cap_w) drop_w = 1'b1;
            if (tx_ready) begin
               if (b_q == KW'(NB - 1))
                  ser_d = SER_IDLE;
               else
                  b_d = b_q + KW'(1);
            end
         end
         default: ser_d = SER_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ser_q <= SER_IDLE;
         b_q   <= '0;
         sh_q  <= '0;
      end else begin
         ser_q <= ser_d;
         b_q   <= b_d;
         sh_q  <= sh_d;
      end
   end

   always_comb begin
      tx_byte_w = 8'h00;
      for (int b = 0; b < NB; b++) begin
         if (b_q == KW'(b)) tx_byte_w = sh_q[b*8 +: 8];
      end
   end

   // ---------------- sticky flags ----------------
   logic overflow_q;
   logic rsp_drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
         rsp_drop_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q | (push & full_w);
         rsp_drop_q <= rsp_drop_q | drop_w;
      end
   end

   // ---------------- outputs ----------------
   assign csoc_clk        = csoc_clk_q;
   assign csoc_rstn       = rstn_q;
   assign csoc_test_se    = se_q;
   assign csoc_test_tm    = tm_q;
   assign csoc_uart_write = write_q;
   assign csoc_data_i     = data_i_q;
   assign fifo_level      = level_q;
   assign overflow        = overflow_q;
   assign rsp_drop        = rsp_drop_q;
   assign tx_valid        = (ser_q == SER_SEND);
   assign tx_data         = tx_valid ? tx_byte_w : 8'h00;

endmodule

// File: tb/tb_csoc_stim_bridge.sv
// ---------------------------------------------------------------------------
// tb_csoc_stim_bridge
//
// Directed bench for csoc_stim_bridge with DATA_W=16, DEPTH=4, CLK_DIV=2,
// RST_CYCLES=4. Inputs change 1 time unit after the rising clk edge;
// monitors sample on the falling clk edge. Launched words and transmitted
// bytes are checked against expected queues filled when stimulus is driven.
// ---------------------------------------------------------------------------
module tb_csoc_stim_bridge;

   localparam int DATA_W     = 16;
   localparam int DEPTH      = 4;
   localparam int CLK_DIV    = 2;
   localparam int RST_CYCLES = 4;
   localparam int LW         = $clog2(DEPTH) + 1;
   localparam int CC_PER     = 2 * CLK_DIV;

   logic              clk;
   logic              rst;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              scan_en;
   logic              test_mode;
   logic              csoc_clk;
   logic              csoc_rstn;
   logic              csoc_test_se;
   logic              csoc_test_tm;
   logic              csoc_uart_write;
   logic              csoc_uart_read;
   logic [DATA_W-1:0] csoc_data_i;
   logic [DATA_W-1:0] csoc_data_o;
   logic [LW-1:0]     fifo_level;
   logic              overflow;
   logic              rsp_drop;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [7:0]        tx_exp_q[$];

   csoc_stim_bridge #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .CLK_DIV   (CLK_DIV),
      .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .scan_en        (scan_en),
      .test_mode      (test_mode),
      .csoc_clk       (csoc_clk),
      .csoc_rstn      (csoc_rstn),
      .csoc_test_se   (csoc_test_se),
      .csoc_test_tm   (csoc_test_tm),
      .csoc_uart_write(csoc_uart_write),
      .csoc_uart_read (csoc_uart_read),
      .csoc_data_i    (csoc_data_i),
      .csoc_data_o    (csoc_data_o),
      .fifo_level     (fifo_level),
      .overflow       (overflow),
      .rsp_drop       (rsp_drop)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until csoc_clk is seen to fall (want_fall=1) or rise.
   task automatic wait_edge(input bit want_fall, output bit ok);
      logic p;
      ok = 1'b0;
      p  = csoc_clk;
      for (int i = 0; i < 64; i++) begin
         step();
         if (want_fall ? (p && !csoc_clk) : (!p && csoc_clk)) begin
            ok = 1'b1;
            break;
         end
         p = csoc_clk;
      end
   endtask

   task automatic check_reset_values();
      chk("rst_csoc_clk",  32'(csoc_clk), 0);
      chk("rst_csoc_rstn", 32'(csoc_rstn), 0);
      chk("rst_write",     32'(csoc_uart_write), 0);
      chk("rst_se",        32'(csoc_test_se), 0);
      chk("rst_tm",        32'(csoc_test_tm), 0);
      chk("rst_tx_valid",  32'(tx_valid), 0);
      chk("rst_overflow",  32'(overflow), 0);
      chk("rst_rsp_drop",  32'(rsp_drop), 0);
      chk("rst_data_i",    32'(csoc_data_i), 0);
      chk("rst_tx_data",   32'(tx_data), 0);
      chk("rst_level",     32'(fifo_level), 0);
   endtask

   // Must be entered right after a fall event with an empty FIFO. Sends one
   // byte per clk; words are {0x80+base+j, base+j}. The model tracks the
   // FIFO using the known fall-event spacing of CC_PER clk.
   int peak;
   task automatic burst(input int nbytes, input logic [7:0] base,
                        output int lvl, output bit ovf);
      int         pre;
      int         j;
      bit         pop_m;
      bit         push_m;
      logic [7:0] lo;
      logic [7:0] hi;
      lvl  = 0;
      ovf  = 1'b0;
      peak = 0;
      for (int t = 1; t <= nbytes; t++) begin
         j  = (t + 1) / 2;
         lo = base + 8'(j);
         hi = 8'h80 + base + 8'(j);
         rx_valid = 1'b1;
         rx_data  = (t % 2 == 1) ? lo : hi;
         pre    = lvl;
         pop_m  = (t % CC_PER == 0) && (pre > 0);
         push_m = 1'b0;
         if (t % 2 == 0) begin
            if (pre == DEPTH) ovf = 1'b1;
            else begin
               push_m = 1'b1;
               exp_q.push_back({hi, lo});
            end
         end
         lvl = pre + int'(push_m) - int'(pop_m);
         step();
         chk("burst_level", 32'(fifo_level), 32'(lvl));
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      rx_valid = 1'b0;
   endtask

   // ---------------- launch monitor ----------------
   initial begin
      logic              p;
      logic [DATA_W-1:0] w;
      p = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) p = 1'b0;
         else begin
            if (p && !csoc_clk && csoc_uart_write) begin
               chk("launch_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  chk("launch_data", 32'(csoc_data_i), 32'(w));
               end
            end
            p = csoc_clk;
         end
      end
   end

   // ---------------- TX monitor ----------------
   initial begin
      bit         stall;
      logic [7:0] held;
      logic [7:0] b;
      stall = 1'b0;
      held  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) stall = 1'b0;
         else begin
            if (stall) begin
               chk("tx_hold_valid", 32'(tx_valid), 1);
               chk("tx_hold_data",  32'(tx_data), 32'(held));
            end
            if (tx_valid && tx_ready) begin
               chk("tx_expected", 32'(tx_exp_q.size() != 0), 1);
               if (tx_exp_q.size() != 0) begin
                  b = tx_exp_q.pop_front();
                  chk("tx_byte", 32'(tx_data), 32'(b));
               end
            end
            stall = tx_valid && !tx_ready;
            held  = tx_data;
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit ok;
      int rise1;
      int rise2;
      int rstn_edge;
      int n_lvl;
      int n_wr;
      int lvl;
      bit ovf;
      logic p;

      rst            = 1'b1;
      rx_valid       = 1'b0;
      rx_data        = 8'h00;
      tx_ready       = 1'b0;
      scan_en        = 1'b0;
      test_mode      = 1'b0;
      csoc_uart_read = 1'b0;
      csoc_data_o    = '0;

      repeat (3) step();
      check_reset_values();

      // Reset release: clock timing, chip reset timing, early bytes ignored.
      rst       = 1'b0;
      rise1     = 0;
      rise2     = 0;
      rstn_edge = 0;
      p         = csoc_clk;
      for (int c = 1; c <= 60; c++) begin
         rx_valid = (c == 3) || (c == 4);
         rx_data  = (c == 3) ? 8'h11 : 8'h22;
         step();
         if (!p && csoc_clk) begin
            if (rise1 == 0) rise1 = c;
            else if (rise2 == 0) rise2 = c;
         end
         p = csoc_clk;
         if (csoc_rstn) begin
            rstn_edge = c;
            break;
         end
      end
      rx_valid = 1'b0;
      chk("first_rise_edge", 32'(rise1), CLK_DIV);
      chk("csoc_clk_period", 32'(rise2 - rise1), CC_PER);
      chk("rstn_release_edge", 32'(rstn_edge), CC_PER * RST_CYCLES);
      chk("rstn_on_fall", 32'(csoc_clk), 0);
      chk("early_bytes_level", 32'(fifo_level), 0);

      // Single word: 0x34, 0x12 -> 0x1234 launched for one chip clock period.
      exp_q.push_back(16'h1234);
      rx_valid = 1'b1;
      rx_data  = 8'h34;
      step();
      rx_data  = 8'h12;
      step();
      rx_valid = 1'b0;
      chk("single_level", 32'(fifo_level), 1);
      n_lvl = 0;
      n_wr  = 0;
      for (int c = 0; c < 12; c++) begin
         if (fifo_level == LW'(1)) n_lvl++;
         if (csoc_uart_write) n_wr++;
         step();
      end
      chk("single_level_window", 32'(n_lvl >= 1 && n_lvl <= CC_PER), 1);
      chk("single_write_width", 32'(n_wr), CC_PER);
      chk("single_level_after", 32'(fifo_level), 0);
      chk("single_launched", 32'(exp_q.size()), 0);

      // Test pins follow scan_en/test_mode only on falling edges.
      wait_edge(1'b1, ok);
      chk("sync_fall_pins", 32'(ok), 1);
      scan_en   = 1'b1;
      test_mode = 1'b1;
      wait_edge(1'b0, ok);
      chk("sync_rise_pins", 32'(ok), 1);
      chk("se_not_on_rise", 32'(csoc_test_se), 0);
      chk("tm_not_on_rise", 32'(csoc_test_tm), 0);
      wait_edge(1'b1, ok);
      chk("se_on_fall", 32'(csoc_test_se), 1);
      chk("tm_on_fall", 32'(csoc_test_tm), 1);

      // Burst of 20 bytes: FIFO fills to DEPTH and words are lost.
      wait_edge(1'b1, ok);
      chk("sync_fall_burst", 32'(ok), 1);
      burst(20, 8'h00, lvl, ovf);
      chk("burst_peak", 32'(peak), DEPTH);
      chk("burst_overflow", 32'(overflow), 32'(ovf));
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) step();
      repeat (2 * CC_PER) step();
      chk("burst_drained", 32'(exp_q.size()), 0);
      chk("burst_level_end", 32'(fifo_level), 0);

      // Capture 0xBEEF with the transmitter ready.
      tx_ready = 1'b1;
      wait_edge(1'b1, ok);
      chk("sync_fall_cap", 32'(ok), 1);
      csoc_data_o    = 16'hBEEF;
      csoc_uart_read = 1'b1;
      tx_exp_q.push_back(8'hEF);
      tx_exp_q.push_back(8'hBE);
      wait_edge(1'b0, ok);
      chk("sync_rise_cap", 32'(ok), 1);
      csoc_uart_read = 1'b0;
      repeat (4) step();
      chk("cap_tx_done", 32'(tx_exp_q.size()), 0);
      chk("cap_tx_idle", 32'(tx_valid), 0);
      chk("cap_no_drop", 32'(rsp_drop), 0);

      // Stalled transmitter: second read word is dropped.
      tx_ready = 1'b0;
      wait_edge(1'b1, ok);
      chk("sync_fall_drop", 32'(ok), 1);
      csoc_data_o    = 16'hCAFE;
      csoc_uart_read = 1'b1;
      tx_exp_q.push_back(8'hFE);
      tx_exp_q.push_back(8'hCA);
      wait_edge(1'b0, ok);
      chk("sync_rise_drop1", 32'(ok), 1);
      csoc_data_o = 16'h5A5A;
      wait_edge(1'b0, ok);
      chk("sync_rise_drop2", 32'(ok), 1);
      csoc_uart_read = 1'b0;
      repeat (4) step();
      chk("drop_flag", 32'(rsp_drop), 1);
      chk("drop_tx_valid", 32'(tx_valid), 1);
      chk("drop_tx_data", 32'(tx_data), 32'h0000_00FE);
      tx_ready = 1'b1;
      repeat (6) step();
      chk("drop_tx_done", 32'(tx_exp_q.size()), 0);
      chk("drop_tx_idle", 32'(tx_valid), 0);
      chk("drop_sticky", 32'(rsp_drop), 1);

      // Reset in the middle of a launch with three words queued.
      wait_edge(1'b1, ok);
      chk("sync_fall_rst", 32'(ok), 1);
      burst(10, 8'h40, lvl, ovf);
      chk("pre_rst_level", 32'(fifo_level), 3);
      chk("pre_rst_write", 32'(csoc_uart_write), 1);
      rst = 1'b1;
      #1;
      check_reset_values();
      exp_q.delete();
      repeat (3) step();
      rst = 1'b0;
      repeat (10 * CC_PER) step();
      chk("post_rst_rstn", 32'(csoc_rstn), 1);
      chk("post_rst_level", 32'(fifo_level), 0);
      chk("post_rst_overflow", 32'(overflow), 0);
      chk("post_rst_write", 32'(csoc_uart_write), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
